// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants and types for the 8-digit multiplexed 7-segment scanner.
//   - SEG_HEX_0..SEG_HEX_F : active-low {dp,g,f,e,d,c,b,a} patterns, dp off
//   - SEG_BLANK / AN_OFF   : all segments off / all digits off
//   - digit_idx_t          : 3-bit digit scan index
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Bit 7 is the decimal point, kept dark (1) for every hex glyph.
  localparam logic [7:0] SEG_HEX_0 = 8'b1_1000000;
  localparam logic [7:0] SEG_HEX_1 = 8'b1_1111001;
  localparam logic [7:0] SEG_HEX_2 = 8'b1_0100100;
  localparam logic [7:0] SEG_HEX_3 = 8'b1_0110000;
  localparam logic [7:0] SEG_HEX_4 = 8'b1_0011001;
  localparam logic [7:0] SEG_HEX_5 = 8'b1_0010010;
  localparam logic [7:0] SEG_HEX_6 = 8'b1_0000010;
  localparam logic [7:0] SEG_HEX_7 = 8'b1_1111000;
  localparam logic [7:0] SEG_HEX_8 = 8'b1_0000000;
  localparam logic [7:0] SEG_HEX_9 = 8'b1_0010000;
  localparam logic [7:0] SEG_HEX_A = 8'b1_0001000;
  localparam logic [7:0] SEG_HEX_B = 8'b1_0000011;
  localparam logic [7:0] SEG_HEX_C = 8'b1_1000110;
  localparam logic [7:0] SEG_HEX_D = 8'b1_0100001;
  localparam logic [7:0] SEG_HEX_E = 8'b1_0000110;
  localparam logic [7:0] SEG_HEX_F = 8'b1_0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to active-low 7-segment decoder (dp always off).
//   nibble : in  [3:0]  hex digit
//   seg    : out [7:0]  {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves seg
    // unassigned; otherwise synthesis infers a latch.
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Shows a 32-bit value as 8 hex digits on a time-multiplexed common-anode
// 7-segment display. New values are captured into a pending register and only
// moved to the display register at frame boundaries, so one frame never mixes
// digits of two different values.
//
// Parameters:
//   SCAN_DIV : clock cycles each digit stays lit (2..2^20)
//   DIGITS   : digits scanned, fixed at 8
// Ports:
//   clk        : in   system clock, rising edge
//   rst_n      : in   asynchronous active-low reset
//   num        : in   [31:0] value to display
//   num_valid  : in   capture strobe for num
//   an         : out  [7:0] digit enables, active-low, an[0] = LS nibble
//   seg        : out  [7:0] segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_done : out  one-cycle pulse after each full 8-digit scan
//
// Build option: define SEG_SCAN_LZ_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
// -----------------------------------------------------------------------------
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       num,
  input  logic              num_valid,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic              frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] prescaler;
  digit_idx_t    index;
  logic [31:0]   pending;
  logic [31:0]   display;
  logic          pend_flag;

  logic          tick;
  logic          boundary;
  logic [3:0]    nibble;
  logic [7:0]    seg_dec;
  logic          blank;

  assign tick     = (prescaler == PW'(SCAN_DIV - 1));
  assign boundary = tick && (index == digit_idx_t'(DIGITS - 1));
  assign nibble   = display[{index, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are 0.
  assign blank = (index != '0) && ((display >> {index, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      index      <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
      display    <= '0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) index <= index + 3'd1;

      // A strobe landing exactly on the boundary goes straight to the display;
      // otherwise the newest strobe waits in pending for the next boundary.
      if (boundary && num_valid) begin
        display   <= num;
        pend_flag <= 1'b0;
      end else if (boundary && pend_flag) begin
        display   <= pending;
        pend_flag <= 1'b0;
      end else if (num_valid) begin
        pending   <= num;
        pend_flag <= 1'b1;
      end

      frame_done <= boundary;

      // Outputs follow the index/display registers by one cycle, so every
      // digit stays lit for exactly SCAN_DIV cycles.
      an  <= ~(DIGITS'(1) << index);
      seg <= blank ? SEG_BLANK : seg_dec;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan
// Directed bench for seg_scan with SCAN_DIV=4 (32-cycle frames). Inputs are
// driven and outputs sampled on the falling clock edge.
// Honors SEG_SCAN_LZ_BLANK_EN for the leading-zero blanking expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] num;
  logic        num_valid;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Expected active-low {dp,g,f,e,d,c,b,a} glyphs, typed in from the hex table.
  logic [7:0] glyph [16] = '{
    8'b1_1000000, 8'b1_1111001, 8'b1_0100100, 8'b1_0110000,
    8'b1_0011001, 8'b1_0010010, 8'b1_0000010, 8'b1_1111000,
    8'b1_0000000, 8'b1_0010000, 8'b1_0001000, 8'b1_0000011,
    8'b1_1000110, 8'b1_0100001, 8'b1_0000110, 8'b1_0001110
  };

  seg_scan #(.SCAN_DIV(SCAN_DIV), .DIGITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .num        (num),
    .num_valid  (num_valid),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [31:0] val, input int d);
    logic [31:0] upper;
    upper = val >> (4 * d);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (d > 0 && upper == 32'd0) return 8'hFF;
`endif
    return glyph[upper[3:0]];
  endfunction

  // Starts at a sample where frame_done is high (the new frame's first digit is
  // applied on the next edge) and ends at the next such sample.
  task automatic check_frame(input string name, input logic [31:0] val);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        @(negedge clk);
        check($sformatf("%s_an_d%0d_c%0d", name, d, c), {24'd0, an}, {24'd0, ~(8'b1 << d)});
        if (c == 0 || c == SCAN_DIV - 1)
          check($sformatf("%s_seg_d%0d_c%0d", name, d, c), {24'd0, seg}, {24'd0, exp_seg(val, d)});
      end
    end
    check($sformatf("%s_frame_done", name), {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_frame_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    check($sformatf("%s_wait_frame_done", name), {31'd0, frame_done}, 32'd1);
  endtask

  task automatic pulse(input logic [31:0] val);
    num       = val;
    num_valid = 1'b1;
    @(negedge clk);
    num_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    num       = 32'd0;
    num_valid = 1'b0;

    // Reset state with the clock running.
    repeat (3) @(negedge clk);
    check("rst_an",         {24'd0, an},         32'hFF);
    check("rst_seg",        {24'd0, seg},        32'hFF);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // Scan sequence after release: two full frames, display=0.
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check($sformatf("scan_an_k%0d", k), {24'd0, an}, {24'd0, ~(8'b1 << (((k - 1) / SCAN_DIV) % 8))});
      check($sformatf("scan_fd_k%0d", k), {31'd0, frame_done}, {31'd0, (k % 32) == 0});
      if ((k - 1) % SCAN_DIV == 0)
        check($sformatf("scan_seg_k%0d", k), {24'd0, seg}, {24'd0, exp_seg(32'd0, ((k - 1) / SCAN_DIV) % 8)});
    end

    // Value display: one strobe mid-frame shows up after the next boundary.
    pulse(32'h0123ABCD);
    wait_frame_done("val");
    check_frame("val", 32'h0123ABCD);

    // Double buffer: two strobes in one frame, only the last one is shown.
    pulse(32'h11111111);
    repeat (5) @(negedge clk);
    pulse(32'h22222222);
    wait_frame_done("dbuf");
    check_frame("dbuf", 32'h22222222);

    // Strobe in the boundary cycle bypasses pending and is shown immediately.
    repeat (31) @(negedge clk);
    pulse(32'hFFFFFFFF);
    check("bnd_frame_done", {31'd0, frame_done},    32'd1);
    check("bnd_pend_flag",  {31'd0, dut.pend_flag}, 32'd0);
    check_frame("bnd", 32'hFFFFFFFF);

    // Mid-frame reset at digit 5 with a pending value that must be discarded.
    pulse(32'h12345678);
    repeat (21) @(negedge clk);
    check("pre_rst_an", {24'd0, an}, 32'hDF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an",         {24'd0, an},         32'hFF);
    check("mid_rst_seg",        {24'd0, seg},        32'hFF);
    check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("post_rst0", 32'd0);
    check_frame("post_rst1", 32'd0);

    // Leading-zero blanking candidate value.
    pulse(32'h000000A5);
    wait_frame_done("lz");
    check_frame("lz", 32'h000000A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
